// File: rtl/a5_pkg.sv
// A5/1 shared types, constants and LFSR step functions.
// Holds the buffer state enum, key/frame/burst sizes, the register triple
// of the cipher and the pure functions that advance it.
package a5_pkg;

  localparam int A5_KEY_W      = 64;
  localparam int A5_FRAME_W    = 22;
  localparam int A5_BURST_BITS = 228;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_RUN,
    ST_DONE
  } a5_buf_state_t;

  // Feedback taps of the three LFSRs (R1 19b, R2 22b, R3 23b).
  localparam logic [18:0] R1_TAPS = 19'h72000;
  localparam logic [21:0] R2_TAPS = 22'h300000;
  localparam logic [22:0] R3_TAPS = 23'h700080;

  typedef struct packed {
    logic [22:0] r3;
    logic [21:0] r2;
    logic [18:0] r1;
  } a5_regs_t;

  // Regular clocking of all three registers with a key/frame bit mixed into bit 0.
  function automatic a5_regs_t a5_clock_all(input a5_regs_t s, input logic b);
    a5_regs_t n;
    n.r1 = {s.r1[17:0], (^(s.r1 & R1_TAPS)) ^ b};
    n.r2 = {s.r2[20:0], (^(s.r2 & R2_TAPS)) ^ b};
    n.r3 = {s.r3[21:0], (^(s.r3 & R3_TAPS)) ^ b};
    return n;
  endfunction

  // Stop/go clocking: a register moves only if its clock bit agrees with the majority.
  function automatic a5_regs_t a5_majority_step(input a5_regs_t s);
    a5_regs_t n;
    logic     maj;
    maj = (s.r1[8] & s.r2[10]) | (s.r1[8] & s.r3[10]) | (s.r2[10] & s.r3[10]);
    n = s;
    if (s.r1[8] == maj)  n.r1 = {s.r1[17:0], ^(s.r1 & R1_TAPS)};
    if (s.r2[10] == maj) n.r2 = {s.r2[20:0], ^(s.r2 & R2_TAPS)};
    if (s.r3[10] == maj) n.r3 = {s.r3[21:0], ^(s.r3 & R3_TAPS)};
    return n;
  endfunction

  function automatic logic a5_out(input a5_regs_t s);
    return s.r1[18] ^ s.r2[21] ^ s.r3[22];
  endfunction

endpackage

// File: rtl/A5Generator.sv
// A5/1 keystream bit generator.
// Latency: key/frame mixed in one cycle on load; d is valid combinationally every cycle after.
// Backpressure: registers advance only when lfsr_clk_en is high; d is held otherwise.
// Ports: load/key/frame initialise the LFSRs; d is the output bit produced by the next
// majority clock, so accepting d on an enabled edge matches the classic clock-then-output order.
module A5Generator
  import a5_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic                  lfsr_clk_en,
  input  logic [A5_KEY_W-1:0]   key,
  input  logic [A5_FRAME_W-1:0] frame,
  output logic                  d
);

  localparam int MIX_BITS = A5_KEY_W + A5_FRAME_W;

  a5_regs_t            regs;
  a5_regs_t            init_regs;
  a5_regs_t            step_regs;
  logic [MIX_BITS-1:0] mix_bits;

  assign mix_bits = {frame, key};

  // The key/frame schedule is linear, so it unrolls into a single-cycle XOR network.
  always_comb begin
    init_regs = '0;
    for (int i = 0; i < MIX_BITS; i++) begin
      init_regs = a5_clock_all(init_regs, mix_bits[i]);
    end
  end

  assign step_regs = a5_majority_step(regs);
  assign d         = a5_out(step_regs);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs <= '0;
    end else if (load) begin
      regs <= init_regs;
    end else if (lfsr_clk_en) begin
      regs <= step_regs;
    end
  end

endmodule

// File: rtl/Fifo.sv
// Generic show-ahead FIFO with occupancy output.
// Latency: a write is visible at rd_data after the writing edge; pops take effect on the next edge.
// Backpressure: writes are dropped while full, reads ignored while empty; flush wins over both.
// Ports: flush/wr_en/wr_data/rd_en in; rd_data (zero when empty), full, empty, level out.
module Fifo #(
  parameter int data_width = 32,
  parameter int depth      = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         wr_en,
  input  logic [data_width-1:0]        wr_data,
  input  logic                         rd_en,
  output logic [data_width-1:0]        rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(depth+1)-1:0]   level
);

  localparam int PTR_W = $clog2(depth);
  localparam int LVL_W = $clog2(depth + 1);

  logic [data_width-1:0] mem [depth];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  do_wr;
  logic                  do_rd;

  assign full    = (level == LVL_W'(depth));
  assign empty   = (level == '0);
  assign do_wr   = wr_en && !full && !flush;
  assign do_rd   = rd_en && !empty && !flush;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/a5_keystream_buffer.sv
// A5/1 keystream buffer: warm-up discard, MSB-first word packing, per-frame bit limit, word FIFO.
// Latency: first word lands in the FIFO on the edge its last bit is accepted (load + WARMUP + WORD_WIDTH).
// Backpressure: generator is held when the next bit would write into a full FIFO; resumes after a pop.
// Ports: load/key/frame start a frame; rd_en pops; data_out (show-ahead), empty, level, done report.
module a5_keystream_buffer
  import a5_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_BITS   = A5_BURST_BITS,
  parameter int WARMUP     = 0
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            load,
  input  logic [A5_KEY_W-1:0]             key,
  input  logic [A5_FRAME_W-1:0]           frame,
  input  logic                            rd_en,
  output logic [WORD_WIDTH-1:0]           data_out,
  output logic                            empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] level,
  output logic                            done
);

  localparam int CNT_W  = (MAX_BITS > 0) ? $clog2(MAX_BITS + 1) : 1;
  localparam int POS_W  = $clog2(WORD_WIDTH);
  localparam int WCNT_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

  a5_buf_state_t         state;
  a5_buf_state_t         state_nxt;
  logic [CNT_W-1:0]      bit_cnt;
  logic [POS_W-1:0]      pos;
  logic [WCNT_W-1:0]     warm_cnt;
  logic [WORD_WIDTH-1:0] pack;
  logic [WORD_WIDTH-1:0] full_word;
  logic [WORD_WIDTH-1:0] wr_word;
  logic                  d;
  logic                  full;
  logic                  last_bit;
  logic                  word_end;
  logic                  stall;
  logic                  accept;
  logic                  lfsr_clk_en;
  logic                  wr_en;

  assign last_bit  = (MAX_BITS != 0) && (bit_cnt == CNT_W'(MAX_BITS - 1));
  assign word_end  = (pos == POS_W'(WORD_WIDTH - 1)) || last_bit;
  assign stall     = word_end && full;
  assign accept    = (state == ST_RUN) && !stall && !load;
  assign wr_en     = accept && word_end;

  assign lfsr_clk_en = (state == ST_WARMUP) || accept;

  // A short final word is shifted up so its bits stay left-aligned with zero fill;
  // for a full word the shift is zero.
  assign full_word = {pack[WORD_WIDTH-2:0], d};
  assign wr_word   = full_word << (POS_W'(WORD_WIDTH - 1) - pos);

  assign done = (state == ST_DONE);

  always_comb begin
    state_nxt = state;
    if (load) begin
      state_nxt = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
    end else begin
      case (state)
        ST_WARMUP: if (warm_cnt == WCNT_W'(WARMUP - 1)) state_nxt = ST_RUN;
        ST_RUN:    if (accept && last_bit)              state_nxt = ST_DONE;
        default:   state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt  <= '0;
      pos      <= '0;
      pack     <= '0;
      warm_cnt <= '0;
    end else if (load) begin
      bit_cnt  <= '0;
      pos      <= '0;
      pack     <= '0;
      warm_cnt <= '0;
    end else begin
      if (state == ST_WARMUP) warm_cnt <= warm_cnt + WCNT_W'(1);
      if (accept) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
        pos     <= word_end ? '0 : pos + POS_W'(1);
        pack    <= word_end ? '0 : full_word;
      end
    end
  end

  A5Generator u_gen (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load),
    .lfsr_clk_en (lfsr_clk_en),
    .key         (key),
    .frame       (frame),
    .d           (d)
  );

  Fifo #(
    .data_width (WORD_WIDTH),
    .depth      (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (load),
    .wr_en   (wr_en),
    .wr_data (wr_word),
    .rd_en   (rd_en),
    .rd_data (data_out),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

endmodule

// File: tb/tb_a5_keystream_buffer.sv
// Self-checking bench for a5_keystream_buffer: default, 8-bit/16-deep and 100-bit warm-up instances
// share clock, reset and load; results are compared against a bit-level A5/1 reference stream.
module tb_a5_keystream_buffer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load = 1'b0;
  logic [63:0] key = '0;
  logic [21:0] frame = '0;
  logic        rd_req = 1'b0;
  int          sel = 0;

  logic        rd0, rd1, rd2;
  logic [31:0] data0, data2;
  logic [7:0]  data1;
  logic        empty0, empty1, empty2;
  logic [2:0]  level0, level2;
  logic [4:0]  level1;
  logic        done0, done1, done2;

  logic [63:0] m_data;
  logic        m_empty, m_done;
  int          m_level;

  int n_checks = 0;
  int n_fail   = 0;

  bit ks [0:399];

  always #5 clk = ~clk;

  assign rd0 = rd_req && (sel == 0);
  assign rd1 = rd_req && (sel == 1);
  assign rd2 = rd_req && (sel == 2);

  a5_keystream_buffer dut (
    .clk(clk), .reset_n(reset_n), .load(load), .key(key), .frame(frame),
    .rd_en(rd0), .data_out(data0), .empty(empty0), .level(level0), .done(done0)
  );

  a5_keystream_buffer #(.WORD_WIDTH(8), .FIFO_DEPTH(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .load(load), .key(key), .frame(frame),
    .rd_en(rd1), .data_out(data1), .empty(empty1), .level(level1), .done(done1)
  );

  a5_keystream_buffer #(.WARMUP(100)) dut_b (
    .clk(clk), .reset_n(reset_n), .load(load), .key(key), .frame(frame),
    .rd_en(rd2), .data_out(data2), .empty(empty2), .level(level2), .done(done2)
  );

  always_comb begin
    m_data  = '0;
    m_empty = 1'b1;
    m_done  = 1'b0;
    m_level = 0;
    case (sel)
      0: begin m_data = 64'(data0); m_empty = empty0; m_done = done0; m_level = int'(level0); end
      1: begin m_data = 64'(data1); m_empty = empty1; m_done = done1; m_level = int'(level1); end
      default: begin m_data = 64'(data2); m_empty = empty2; m_done = done2; m_level = int'(level2); end
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference A5/1: 64 key + 22 frame regular clocks, then one majority clock per output bit.
  task automatic gen_ref(input logic [63:0] k, input logic [21:0] f);
    int r1, r2, r3, kb, b1, b2, b3, maj;
    r1 = 0; r2 = 0; r3 = 0;
    for (int i = 0; i < 86; i++) begin
      kb = (i < 64) ? int'(k[i]) : int'(f[i-64]);
      r1 = (((r1 << 1) | int'(^(r1 & 32'h072000))) & 32'h07FFFF) ^ kb;
      r2 = (((r2 << 1) | int'(^(r2 & 32'h300000))) & 32'h3FFFFF) ^ kb;
      r3 = (((r3 << 1) | int'(^(r3 & 32'h700080))) & 32'h7FFFFF) ^ kb;
    end
    for (int j = 0; j < 400; j++) begin
      b1 = (r1 >> 8) & 1;
      b2 = (r2 >> 10) & 1;
      b3 = (r3 >> 10) & 1;
      maj = (b1 + b2 + b3 >= 2) ? 1 : 0;
      if (b1 == maj) r1 = ((r1 << 1) | int'(^(r1 & 32'h072000))) & 32'h07FFFF;
      if (b2 == maj) r2 = ((r2 << 1) | int'(^(r2 & 32'h300000))) & 32'h3FFFFF;
      if (b3 == maj) r3 = ((r3 << 1) | int'(^(r3 & 32'h700080))) & 32'h7FFFFF;
      ks[j] = bit'(((r1 >> 18) ^ (r2 >> 21) ^ (r3 >> 22)) & 1);
    end
  endtask

  // Word idx of a 228-bit frame, MSB first, zero beyond the frame end.
  function automatic logic [63:0] exp_word(input int w, input int warm, input int idx);
    logic [63:0] r;
    int p;
    r = '0;
    for (int b = 0; b < w; b++) begin
      p = idx * w + b;
      if (p < 228) r[w-1-b] = ks[warm + p];
    end
    return r;
  endfunction

  task automatic pulse_load(input logic [63:0] k, input logic [21:0] f);
    @(negedge clk);
    key = k; frame = f; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    gen_ref(k, f);
  endtask

  // Pop words at one every gap+1 cycles until done and empty, comparing each against the model.
  task automatic drain(input int s, input int gap, input int w, input int warm,
                       input int nwords, input int first, input string tag);
    int  widx, cyc;
    bit  done_seen;
    widx = first; cyc = 0; done_seen = 0;
    sel = s;
    while (cyc < 3000) begin
      @(negedge clk);
      rd_req = 1'b0;
      if (m_done && !done_seen) begin
        done_seen = 1;
        check({tag, "_done_count"}, 64'(widx + m_level), 64'(nwords));
      end
      if (m_done && m_empty) break;
      if (!m_empty && (cyc % (gap + 1) == 0)) begin
        check({tag, "_word"}, m_data, exp_word(w, warm, widx));
        widx++;
        rd_req = 1'b1;
      end
      cyc++;
    end
    rd_req = 1'b0;
    check({tag, "_in_time"}, 64'(cyc < 3000), 64'd1);
    check({tag, "_nwords"}, 64'(widx), 64'(nwords));
    check({tag, "_done"}, 64'(m_done), 64'd1);
    repeat (20) @(negedge clk);
    check({tag, "_empty_after_done"}, 64'(m_empty), 64'd1);
  endtask

  typedef struct {
    logic [63:0] k;
    logic [21:0] f;
    int          gap;
    int          words;
  } vec_t;

  vec_t vt [5];

  initial begin
    vt[0] = '{64'h1223456789ABCDEF, 22'h134, 0, 8};
    vt[1] = '{64'h0000000000000001, 22'h000001, 2, 8};
    vt[2] = '{64'hFFFFFFFFFFFFFFFF, 22'h3FFFFF, 37, 8};
    vt[3] = '{{$urandom, $urandom}, 22'($urandom), 70, 8};
    vt[4] = '{{$urandom, $urandom}, 22'($urandom), int'($urandom_range(1, 5)), 8};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_empty", 64'(empty0), 64'd1);
    check("rst_level", 64'(level0), 64'd0);
    check("rst_done", 64'(done0), 64'd0);
    check("rst_data", 64'(data0), 64'd0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_no_write", 64'(empty0), 64'd1);

    // Load-to-data latency on all three instances, then drain each.
    pulse_load(64'h0123456789ABCDEF, 22'h2A5A5);
    for (int i = 1; i <= 132; i++) begin
      @(negedge clk);
      if (i == 7)   check("lat_a_before", 64'(empty1), 64'd1);
      if (i == 8)   check("lat_a_after", 64'(empty1), 64'd0);
      if (i == 31)  check("lat_def_before", 64'(empty0), 64'd1);
      if (i == 32)  check("lat_def_after", 64'(empty0), 64'd0);
      if (i == 131) check("lat_b_before", 64'(empty2), 64'd1);
      if (i == 132) check("lat_b_after", 64'(empty2), 64'd0);
    end
    drain(2, 0, 32, 100, 8, 0, "warmup");
    drain(1, 0, 8, 0, 29, 0, "w8");
    drain(0, 0, 32, 0, 8, 0, "def_stalled");

    // Table of frames with varied read pacing.
    for (int t = 0; t < 5; t++) begin
      pulse_load(vt[t].k, vt[t].f);
      drain(0, vt[t].gap, 32, 0, vt[t].words, 0, $sformatf("tbl%0d", t));
    end

    // Backpressure: fill, pop one, refill, then verify the whole stream.
    pulse_load(64'hDEADBEEFCAFEF00D, 22'h155);
    repeat (200) @(negedge clk);
    sel = 0;
    check("bp_full_level", 64'(level0), 64'd4);
    check("bp_not_done", 64'(done0), 64'd0);
    check("bp_head", 64'(data0), exp_word(32, 0, 0));
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    check("bp_level_after_pop", 64'(level0), 64'd3);
    repeat (32) @(negedge clk);
    check("bp_level_refill", 64'(level0), 64'd4);
    drain(0, 0, 32, 0, 8, 1, "bp");

    // Load mid-frame with rd_en asserted in the same cycle.
    begin
      int waited;
      pulse_load(64'h5555AAAA5555AAAA, 22'h0F0F0);
      waited = 0;
      while (level0 != 3'd3 && waited < 300) begin
        @(negedge clk);
        waited++;
      end
      check("mid_reach_3", 64'(level0), 64'd3);
      key = 64'h0F1E2D3C4B5A6978; frame = 22'h2C3D4; load = 1'b1; rd_req = 1'b1;
      @(negedge clk);
      load = 1'b0; rd_req = 1'b0;
      gen_ref(64'h0F1E2D3C4B5A6978, 22'h2C3D4);
      check("mid_empty", 64'(empty0), 64'd1);
      check("mid_level", 64'(level0), 64'd0);
      check("mid_done", 64'(done0), 64'd0);
      drain(0, 1, 32, 0, 8, 0, "mid");
    end

    // Asynchronous reset mid-frame.
    pulse_load(64'h13579BDF2468ACE0, 22'h1234);
    repeat (50) @(negedge clk);
    check("pre_rst_level", 64'(level0), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_empty", 64'(empty0), 64'd1);
    check("arst_level", 64'(level0), 64'd0);
    check("arst_done", 64'(done0), 64'd0);
    check("arst_data", 64'(data0), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (80) @(negedge clk);
    check("post_rst_empty", 64'(empty0), 64'd1);
    check("post_rst_level", 64'(level0), 64'd0);
    check("post_rst_a_empty", 64'(empty1), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/a5_keystream_buffer.md
# a5_keystream_buffer

Parametrised A5/1 keystream buffer: it drives an `A5Generator`, optionally discards warm-up bits, packs the serial keystream MSB-first into `WORD_WIDTH`-bit words and queues them in a `FIFO_DEPTH`-entry FIFO for a bus-side reader. It replaces the fixed 32-bit/4-deep buffer behind the Wishbone register block. New behaviour over that buffer:
- configurable word width and FIFO depth;
- per-frame bit limit (228 for one GSM burst pair) with zero-padded final word and a `done` flag;
- warm-up discard;
- FIFO level reporting.

## Interface
- `WORD_WIDTH`, 32: bits per output word, 8..64.
- `FIFO_DEPTH`, 4: FIFO entries, power of two, at least 2.
- `MAX_BITS`, 228: keystream bits per frame. 0 means unlimited.
- `WARMUP`, 0: generator-enabled cycles whose output bit is discarded after each load.
- `clk` in 1: clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `load` in 1: one-cycle pulse. Loads `key`/`frame`, flushes the FIFO and packer, restarts the frame.
- `key` in 64: session key Kc, sampled when `load` is high.
- `frame` in 22: frame number, sampled when `load` is high.
- `rd_en` in 1: pop the FIFO head. Ignored when `empty`.
- `data_out` out `WORD_WIDTH`: FIFO head (show-ahead). Valid when `!empty`.
- `empty` out 1: FIFO empty.
- `level` out `$clog2(FIFO_DEPTH+1)`: number of words currently in the FIFO.
- `done` out 1: all `MAX_BITS` bits of the current frame have been written to the FIFO. Always 0 when `MAX_BITS` is 0.

## Operation
- **States:** IDLE, WARMUP, RUN, DONE.
- **Reset:** state IDLE, `empty`=1, `level`=0, `data_out`=0, `done`=0, packer cleared, generator disabled.
- **Load:** `load` from any state goes to WARMUP (RUN if `WARMUP`=0). It clears the bit counter, packer and FIFO, and deasserts `done`. It takes priority over `rd_en` and any write in the same cycle.
- **WARMUP:** the generator is enabled every cycle and its bits are dropped. After `WARMUP` cycles the state goes to RUN. The FIFO is not involved.
- **RUN:**
  - One bit is accepted per cycle from `A5Generator.d` while `lfsr_clk_en` is high.
  - `stall` = (the next bit completes a word or is bit `MAX_BITS`) and the FIFO is full.
  - `lfsr_clk_en` = WARMUP or (RUN and !`stall`).
- **Packing:**
  - The first accepted bit lands in the MSB. A full word is `{pack[WORD_WIDTH-2:0], d}`.
  - That word is written to the FIFO on the same edge the last bit is accepted. There is no extra cycle.
- **Frame limit:**
  - When bit `MAX_BITS` is accepted, the partial word is written left-aligned with its low bits zero-padded. The state then goes to DONE.
  - If `MAX_BITS` is a multiple of `WORD_WIDTH`, the final word is a normal full word.
- **DONE:** generator disabled, `done`=1. The FIFO still drains normally.
- **IDLE:** generator disabled. Nothing is written until the first `load`.
- **FIFO:**
  - A write is blocked by `full` even if `rd_en` is high in the same cycle. This never occurs, because `stall` prevents it.
  - A read and a write in the same cycle leave `level` unchanged.
- **Reset mid-frame:** all state returns to reset values immediately. Everything in flight is lost.

## Timing
- **Load-to-data latency:** with `load` sampled at edge k and no stall, bits are accepted at edges k+1+`WARMUP` .. k+`WORD_WIDTH`+`WARMUP`. `empty` falls after edge k+`WORD_WIDTH`+`WARMUP`.
- **Throughput:** one bit per clock in RUN, so one word per `WORD_WIDTH` clocks.
- **Read path:** `rd_en` at edge n updates `data_out`/`level`/`empty` after edge n.
- **Backpressure:** the generator stays held (no LFSR advance) while `stall` is high. It resumes on the cycle after a pop. The keystream is bit-identical to an unstalled run.
- **`done`:** rises after the edge that writes the final word.

## Structure
- **Package `a5_pkg`:** state enum `a5_buf_state_t`, and `A5_KEY_W`=64, `A5_FRAME_W`=22, `A5_BURST_BITS`=228.
- **Sub-modules:**
  - Existing `A5Generator` (ports `clk`, `reset_n`, `load`, `lfsr_clk_en`, `key`, `frame`, `d`).
  - Existing `Fifo` (`data_width`, `depth`, `flush`, `wr_en`/`rd_en`, `full`/`empty`), extended with a `level` output.
- **This module:** FSM, bit counter (width `$clog2(MAX_BITS+1)`), packer.

## Test plan
- **Reset:** assert `reset_n`=0 mid-RUN → `empty`=1, `level`=0, `done`=0, `data_out`=0. No FIFO writes until the next `load`.
- **Default parameters:** load, drain continuously → exactly 8 words. Words 0–6 match the golden A5/1 model bits 0–223. Word 7 = bits 224–227 in [31:28], [27:0]=0. `done`=1 after the 8th write.
- **Backpressure:** load, no reads → `level`=4, `lfsr_clk_en` held low. Pop one → `level`=3, then 4 again after 32 cycles. The total stream matches an unstalled run.
- **Load mid-frame:** `load` with 3 words queued and `rd_en` high → `empty`=1 the next cycle. The new stream matches the model for the new `key`/`frame`.
- **Variant A:** `WORD_WIDTH`=8, `FIFO_DEPTH`=16 → 28 full words plus 1 word with bits [7:4] valid and [3:0]=0.
- **Variant B:** `WARMUP`=100 → first word equals model bits 100–131. `empty` falls after edge k+132.
